serial_to_parallel: RTL

//   Deserializer that consumes the registered serial bit stream from the D flip-flop stage.

---
 rtl/serial_to_parallel.sv | 136 +++++++++++++
 1 files changed

// File: rtl/serial_to_parallel.sv
// ----------------------------------------------------------------------------
// serial_to_parallel
//   Deserializer for the registered serial bit stream coming from the upstream
//   D flip-flop stage. It collects WIDTH qualified bits into a word. The word
//   is then held in a one-word valid/ready output buffer. If a word completes
//   while the buffer is still full, that word is dropped and the sticky
//   overrun flag is raised.
//
// Parameters
//   WIDTH      bits per word (2..32)
//   MSB_FIRST  1: first received bit ends up in dout[WIDTH-1]
//              0: first received bit ends up in dout[0]
//
// Ports
//   clk        in   rising-edge clock
//   reset      in   asynchronous, active-low reset
//   din        in   serial data bit
//   din_valid  in   din is qualified on this edge
//   sync       in   frame restart: discard the partial word
//   dout       out  assembled word (WIDTH bits)
//   dout_valid out  dout holds an unconsumed word
//   dout_ready in   consumer takes dout on this edge
//   overrun    out  sticky: a completed word was dropped
//   clr_ovr    in   clears overrun (a simultaneous drop wins)
//   bit_cnt    out  bits held in the current partial word
//
// Output buffer states
//   state   | meaning
//   S_EMPTY | no word pending, dout_valid = 0, dout keeps its last value
//   S_FULL  | dout holds an unconsumed word, dout_valid = 1
// ----------------------------------------------------------------------------
module serial_to_parallel #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             din,
    input  logic             din_valid,
    input  logic             sync,
    output logic [WIDTH-1:0] dout,
    output logic             dout_valid,
    input  logic             dout_ready,
    output logic             overrun,
    input  logic             clr_ovr,
    output logic [4:0]       bit_cnt
);

    typedef enum logic {
        S_EMPTY = 1'b0,
        S_FULL  = 1'b1
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_shift;
    logic [WIDTH-1:0] r_dout;
    logic [4:0]       r_cnt;
    logic             r_ovr;

    logic             w_last;
    logic             w_complete;
    logic [WIDTH-1:0] w_shifted;
    logic [WIDTH-1:0] w_seed;

    assign w_last = (r_cnt == 5'(WIDTH - 1));

    // sync always wins over completion, so a sync on the last bit yields no word.
    assign w_complete = din_valid && !sync && w_last;

    // Shift register contents after taking din. On the completing edge this
    // is the finished word.
    assign w_shifted = MSB_FIRST ? {r_shift[WIDTH-2:0], din}
                                 : {din, r_shift[WIDTH-1:1]};

    // This is the first bit of a new frame when sync and din_valid
    // arrive together.
    assign w_seed = MSB_FIRST ? {{(WIDTH-1){1'b0}}, din}
                              : {din, {(WIDTH-1){1'b0}}};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_shift <= '0;
            r_cnt   <= '0;
        end else if (sync) begin
            r_shift <= din_valid ? w_seed : '0;
            r_cnt   <= din_valid ? 5'd1 : 5'd0;
        end else if (din_valid) begin
            if (w_last) begin
                r_shift <= '0;
                r_cnt   <= '0;
            end else begin
                r_shift <= w_shifted;
                r_cnt   <= r_cnt + 5'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_EMPTY;
            r_dout  <= '0;
            r_ovr   <= 1'b0;
        end else begin
            // A drop assigned later in this block overrides the clear.
            if (clr_ovr)
                r_ovr <= 1'b0;
            case (r_state)
                S_EMPTY: begin
                    if (w_complete) begin
                        r_dout  <= w_shifted;
                        r_state <= S_FULL;
                    end
                end
                S_FULL: begin
                    if (dout_ready) begin
                        // Reload on the same edge when a new word completes,
                        // so there is no empty cycle between words.
                        if (w_complete)
                            r_dout <= w_shifted;
                        else
                            r_state <= S_EMPTY;
                    end else if (w_complete) begin
                        r_ovr <= 1'b1;
                    end
                end
                default: r_state <= S_EMPTY;
            endcase
        end
    end

    assign dout       = r_dout;
    assign dout_valid = (r_state == S_FULL);
    assign overrun    = r_ovr;
    assign bit_cnt    = r_cnt;

endmodule
